// File: rtl/exanet_crosb_pkg.sv
// Shared types, state encoding and width helper for the VC credit scheduler.
package exanet_crosb_pkg;

    localparam int PRIO_NUM_DFLT   = 2;
    localparam int VC_NUM_DFLT     = 2;
    localparam int CREDIT_MAX_DFLT = 16;

    // Index width that never collapses to zero bits for a single entry.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [$clog2(PRIO_NUM_DFLT*VC_NUM_DFLT)-1:0] vc_id_t;
    typedef logic [$clog2(CREDIT_MAX_DFLT+1)-1:0]         credit_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } sched_state_e;

endpackage

// File: rtl/exa_vc_credit_sched_if.sv
// Request/credit inputs and grant/credit outputs of the VC credit scheduler.
interface exa_vc_credit_sched_if #(
    parameter int N  = 4,
    parameter int CW = 5
);
    import exanet_crosb_pkg::*;

    localparam int VW = idx_w(N);

    logic [N-1:0]    i_req;
    logic            i_flit_sent;
    logic            i_last_sent;
    logic [N-1:0]    i_credit_ret;
    logic            o_grant_valid;
    logic [VW-1:0]   o_grant_vc;
    logic            o_flit_allow;
    logic [N*CW-1:0] o_credit;
    logic            o_credit_err;

    modport master (
        output i_req, i_flit_sent, i_last_sent, i_credit_ret,
        input  o_grant_valid, o_grant_vc, o_flit_allow, o_credit, o_credit_err
    );

    modport slave (
        input  i_req, i_flit_sent, i_last_sent, i_credit_ret,
        output o_grant_valid, o_grant_vc, o_flit_allow, o_credit, o_credit_err
    );

endinterface

// File: rtl/exa_vc_credit_cnt.sv
// Per-VC saturating credit counter; err pulses when an update would leave 0..credit_max.
module exa_vc_credit_cnt #(
    parameter int credit_max = 16,
    parameter int CW         = 5
) (
    input  logic          S_ACLK,
    input  logic          S_ARESETN,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          err
);

    logic at_max, at_zero;

    assign at_max  = (count == CW'(credit_max));
    assign at_zero = (count == '0);
    assign err     = (inc & ~dec & at_max) | (dec & ~inc & at_zero);

    always_ff @(posedge S_ACLK or negedge S_ARESETN) begin
        if (!S_ARESETN)
            count <= CW'(credit_max);
        else if (inc & ~dec & ~at_max)
            count <= count + 1'b1;
        else if (dec & ~inc & ~at_zero)
            count <= count - 1'b1;
    end

endmodule

// File: rtl/ss_out_rr.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
module ss_out_rr
    import exanet_crosb_pkg::*;
#(
    parameter int W = 2,
    localparam int IW = idx_w(W)
) (
    input  logic [W-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    always_comb begin
        int j;
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int i = 1; i <= W; i++) begin
            j = (int'(ptr) + i) % W;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/exa_vc_credit_sched.sv
// Strict-priority, per-level round-robin packet scheduler over credit-gated VCs.
module exa_vc_credit_sched
    import exanet_crosb_pkg::*;
#(
    parameter int prio_num   = PRIO_NUM_DFLT,
    parameter int vc_num     = VC_NUM_DFLT,
    parameter int credit_max = CREDIT_MAX_DFLT
) (
    input logic                  S_ACLK,
    input logic                  S_ARESETN,
    exa_vc_credit_sched_if.slave bus
);

    localparam int N  = prio_num * vc_num;
    localparam int CW = $clog2(credit_max + 1);
    localparam int VW = idx_w(N);
    localparam int IW = idx_w(vc_num);

    if (prio_num < 1 || prio_num > 8) begin : g_prio_chk
        $error("exa_vc_credit_sched: prio_num must be in 1..8");
    end

    sched_state_e                 state, state_nxt;
    logic [VW-1:0]                grant_vc, win_vc;
    logic [prio_num-1:0][IW-1:0]  rr_ptr, lvl_idx;
    logic [prio_num-1:0]          lvl_any, win_oh;
    logic [N-1:0]                 eligible, dec, cnt_err;
    logic [N-1:0][CW-1:0]         credit;
    logic                         in_grant, win_any, grant_fire, err_q;

    assign in_grant   = (state == ST_GRANT);
    assign grant_fire = ~in_grant & win_any;

    // Sends outside a grant never reach the counters; they only flag err.
    for (genvar k = 0; k < N; k++) begin : g_cnt
        assign dec[k]      = bus.i_flit_sent & in_grant & (grant_vc == VW'(k));
        assign eligible[k] = bus.i_req[k] & (credit[k] != '0);

        exa_vc_credit_cnt #(.credit_max(credit_max), .CW(CW)) u_cnt (
            .S_ACLK    (S_ACLK),
            .S_ARESETN (S_ARESETN),
            .inc       (bus.i_credit_ret[k]),
            .dec       (dec[k]),
            .count     (credit[k]),
            .err       (cnt_err[k])
        );
    end

    for (genvar p = 0; p < prio_num; p++) begin : g_lvl
        ss_out_rr #(.W(vc_num)) u_rr (
            .req (eligible[p*vc_num +: vc_num]),
            .ptr (rr_ptr[p]),
            .any (lvl_any[p]),
            .idx (lvl_idx[p])
        );
    end

    // Ascending scan: the highest eligible level overwrites lower ones.
    always_comb begin
        win_any = 1'b0;
        win_oh  = '0;
        win_vc  = '0;
        for (int p = 0; p < prio_num; p++) begin
            if (lvl_any[p]) begin
                win_any   = 1'b1;
                win_oh    = '0;
                win_oh[p] = 1'b1;
                win_vc    = VW'(p * vc_num + int'(lvl_idx[p]));
            end
        end
    end

    always_ff @(posedge S_ACLK or negedge S_ARESETN) begin
        if (!S_ARESETN)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (win_any) state_nxt = ST_GRANT;
            ST_GRANT: if (bus.i_flit_sent & bus.i_last_sent) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_ACLK or negedge S_ARESETN) begin
        if (!S_ARESETN) begin
            grant_vc <= '0;
            err_q    <= 1'b0;
            for (int p = 0; p < prio_num; p++)
                rr_ptr[p] <= IW'(vc_num - 1);
        end else begin
            if (grant_fire)
                grant_vc <= win_vc;
            for (int p = 0; p < prio_num; p++)
                if (grant_fire & win_oh[p])
                    rr_ptr[p] <= lvl_idx[p];
            err_q <= err_q | (|cnt_err) | (~in_grant & (bus.i_flit_sent | bus.i_last_sent));
        end
    end

    assign bus.o_grant_valid = in_grant;
    assign bus.o_grant_vc    = grant_vc;
    assign bus.o_flit_allow  = in_grant & (credit[grant_vc] != '0);
    assign bus.o_credit      = credit;
    assign bus.o_credit_err  = err_q;

endmodule

// File: tb/tb_exa_vc_credit_sched.sv
// Directed bench for exa_vc_credit_sched with a per-cycle reference model.
module tb_exa_vc_credit_sched;
    import exanet_crosb_pkg::*;

    localparam int P    = 2;
    localparam int V    = 2;
    localparam int N    = P * V;
    localparam int CMAX = 16;
    localparam int CW   = 5;

    logic S_ACLK    = 1'b0;
    logic S_ARESETN = 1'b0;
    always #5 S_ACLK = ~S_ACLK;

    exa_vc_credit_sched_if #(.N(N), .CW(CW)) bus();

    exa_vc_credit_sched #(.prio_num(P), .vc_num(V), .credit_max(CMAX)) dut (
        .S_ACLK    (S_ACLK),
        .S_ARESETN (S_ARESETN),
        .bus       (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: who holds the packet grant, credits as plain integers.
    bit m_gv;
    bit m_err;
    int m_vc;
    int m_credit[N];
    int m_ptr[P];

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic credit_t cred(input int k);
        return bus.o_credit[k*CW +: CW];
    endfunction

    task automatic model_reset();
        m_gv  = 0;
        m_err = 0;
        m_vc  = 0;
        for (int k = 0; k < N; k++) m_credit[k] = CMAX;
        for (int l = 0; l < P; l++) m_ptr[l] = V - 1;
    endtask

    task automatic model_update(input logic [N-1:0] req, input logic fs, input logic ls,
                                input logic [N-1:0] cr);
        int dec_vc;
        int v;
        int c;
        dec_vc = -1;
        if (!m_gv) begin
            if (fs || ls) m_err = 1;
            for (int l = P - 1; l >= 0; l--) begin
                for (int i = 1; i <= V; i++) begin
                    v = (m_ptr[l] + i) % V;
                    if (!m_gv && req[l*V+v] && m_credit[l*V+v] > 0) begin
                        m_gv     = 1;
                        m_vc     = l * V + v;
                        m_ptr[l] = v;
                    end
                end
            end
        end else begin
            if (fs) dec_vc = m_vc;
            if (fs && ls) m_gv = 0;
        end
        for (int k = 0; k < N; k++) begin
            c = m_credit[k] + int'(cr[k]) - ((k == dec_vc) ? 1 : 0);
            if (c > CMAX) begin c = CMAX; m_err = 1; end
            if (c < 0)    begin c = 0;    m_err = 1; end
            m_credit[k] = c;
        end
    endtask

    task automatic tick();
        logic [N-1:0] r;
        logic [N-1:0] cr;
        logic         fs;
        logic         ls;
        r  = bus.i_req;
        cr = bus.i_credit_ret;
        fs = bus.i_flit_sent;
        ls = bus.i_last_sent;
        @(posedge S_ACLK);
        if (S_ARESETN) model_update(r, fs, ls, cr);
        #1;
    endtask

    always @(negedge S_ACLK) begin
        if (S_ARESETN) begin
            check("grant_valid", bus.o_grant_valid, m_gv);
            if (m_gv) check("grant_vc", bus.o_grant_vc, m_vc);
            check("flit_allow", bus.o_flit_allow, m_gv && m_credit[m_vc] > 0);
            for (int k = 0; k < N; k++)
                check($sformatf("credit[%0d]", k), cred(k), m_credit[k]);
            check("credit_err", bus.o_credit_err, m_err);
        end
    end

    int exp_rr[4] = '{0, 1, 0, 1};

    initial begin
        bus.i_req        = '0;
        bus.i_credit_ret = '0;
        bus.i_flit_sent  = 1'b0;
        bus.i_last_sent  = 1'b0;
        model_reset();
        repeat (2) tick();
        S_ARESETN = 1'b1;
        for (int k = 0; k < N; k++) check("reset_credit", cred(k), 16);
        check("reset_grant_valid", bus.o_grant_valid, 0);
        check("reset_err", bus.o_credit_err, 0);

        // Round robin inside level 0 with 1-flit packets
        bus.i_req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_grant_valid", bus.o_grant_valid, 1);
            check("rr_grant_vc", bus.o_grant_vc, exp_rr[i]);
            bus.i_flit_sent = 1'b1;
            bus.i_last_sent = 1'b1;
            tick();
            bus.i_flit_sent = 1'b0;
            bus.i_last_sent = 1'b0;
            check("rr_idle_gap", bus.o_grant_valid, 0);
        end
        bus.i_req        = '0;
        bus.i_credit_ret = 4'b0011;
        repeat (2) tick();
        bus.i_credit_ret = '0;
        check("rr_credit_back", cred(0), 16);

        // Priority: level 1 beats level 0
        bus.i_req = 4'b0101;
        tick();
        check("prio_first", bus.o_grant_vc, 2);
        bus.i_flit_sent = 1'b1;
        bus.i_last_sent = 1'b1;
        bus.i_req       = 4'b0001;
        tick();
        bus.i_flit_sent = 1'b0;
        bus.i_last_sent = 1'b0;
        check("prio_vc2_credit", cred(2), 15);
        tick();
        check("prio_second", bus.o_grant_vc, 0);
        bus.i_flit_sent = 1'b1;
        bus.i_last_sent = 1'b1;
        bus.i_req       = '0;
        tick();
        bus.i_flit_sent  = 1'b0;
        bus.i_last_sent  = 1'b0;
        bus.i_credit_ret = 4'b0101;
        tick();
        bus.i_credit_ret = '0;

        // Credit exhaustion on VC1, stall, then refill
        bus.i_req = 4'b0010;
        tick();
        check("exh_grant_vc", bus.o_grant_vc, 1);
        bus.i_flit_sent = 1'b1;
        repeat (16) tick();
        bus.i_flit_sent = 1'b0;
        check("exh_credit0", cred(1), 0);
        check("exh_allow0", bus.o_flit_allow, 0);
        check("exh_grant_held", bus.o_grant_valid, 1);
        bus.i_req = '0;
        tick();
        check("req_drop_holds", bus.o_grant_valid, 1);
        bus.i_credit_ret = 4'b0010;
        tick();
        bus.i_credit_ret = '0;
        check("refill_credit", cred(1), 1);
        check("refill_allow", bus.o_flit_allow, 1);
        bus.i_flit_sent  = 1'b1;
        bus.i_credit_ret = 4'b0010;
        tick();
        bus.i_credit_ret = '0;
        check("simul_ret_send", cred(1), 1);
        bus.i_last_sent = 1'b1;
        tick();
        bus.i_flit_sent  = 1'b0;
        bus.i_last_sent  = 1'b0;
        bus.i_credit_ret = 4'b0010;
        repeat (16) tick();
        check("full_no_err", bus.o_credit_err, 0);
        check("full_credit", cred(1), 16);
        tick();
        bus.i_credit_ret = '0;
        check("overflow_hold", cred(1), 16);
        check("overflow_err", bus.o_credit_err, 1);

        // Reset in the middle of a packet
        bus.i_req = 4'b0001;
        tick();
        bus.i_req       = '0;
        bus.i_flit_sent = 1'b1;
        tick();
        bus.i_flit_sent = 1'b0;
        check("mid_pkt_credit", cred(0), 15);
        #2;
        S_ARESETN = 1'b0;
        #1;
        check("async_grant_valid", bus.o_grant_valid, 0);
        check("async_allow", bus.o_flit_allow, 0);
        check("async_err", bus.o_credit_err, 0);
        model_reset();
        tick();
        S_ARESETN = 1'b1;
        check("reload_credit0", cred(0), 16);

        // Footer handshake while idle: ignored but flagged
        bus.i_flit_sent = 1'b1;
        bus.i_last_sent = 1'b1;
        tick();
        bus.i_flit_sent = 1'b0;
        bus.i_last_sent = 1'b0;
        check("idle_send_err", bus.o_credit_err, 1);
        check("idle_send_credit", cred(0), 16);
        check("idle_send_state", bus.o_grant_valid, 0);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
